// File: rtl/pci_target_dphase_ctrl_if.sv
// Bus-side and backend-side signals of the PCI target data-phase controller.
// slave is the controller's view, master is the environment driving it.
interface pci_target_dphase_ctrl_if;
    logic        START_CFG_I;
    logic        START_MEM_I;
    logic        START_HPMEM_I;
    logic        WR_I;
    logic [21:0] ADD_I;
    logic        FRAMEn_I;
    logic        IRDYn_I;
    logic        TRDYn_O;
    logic        STOPn_O;
    logic        AD_OE_O;
    logic        BUSY_O;
    logic [1:0]  LOC_SEL_O;
    logic [21:0] LOC_ADD_O;
    logic        LOC_WE_O;
    logic        LOC_STB_O;
    logic        LOC_RDY_I;
    logic        END_CFG_O;
    logic        END_MEM_O;
    logic        END_HPMEM_O;

    modport slave (
        input  START_CFG_I, START_MEM_I, START_HPMEM_I, WR_I, ADD_I,
        input  FRAMEn_I, IRDYn_I, LOC_RDY_I,
        output TRDYn_O, STOPn_O, AD_OE_O, BUSY_O,
        output LOC_SEL_O, LOC_ADD_O, LOC_WE_O, LOC_STB_O,
        output END_CFG_O, END_MEM_O, END_HPMEM_O
    );

    modport master (
        output START_CFG_I, START_MEM_I, START_HPMEM_I, WR_I, ADD_I,
        output FRAMEn_I, IRDYn_I, LOC_RDY_I,
        input  TRDYn_O, STOPn_O, AD_OE_O, BUSY_O,
        input  LOC_SEL_O, LOC_ADD_O, LOC_WE_O, LOC_STB_O,
        input  END_CFG_O, END_MEM_O, END_HPMEM_O
    );
endinterface

// File: rtl/pci_target_dphase_ctrl.sv
// PCI target data-phase sequencer shared by the CFG, MEM and HPMEM backends.
// state    | meaning
// IDLE     | waiting for a claim pulse from the address decoder
// TURNAR   | read turnaround, AD driver enabled, no TRDY#
// DPHASE   | data phases run, TRDY# follows LOC_RDY
// STOPPING | STOP# asserted (disconnect/retry) until FRAME# deasserts
// FINISH   | bus released, last strobe out; END pulse follows
module pci_target_dphase_ctrl #(
    parameter int MAX_BURST = 16,
    parameter int INIT_LAT  = 16,
    parameter int SUBS_LAT  = 8
) (
    input  logic                           PHY_CLK33_I,
    input  logic                           PHY_RST_I,
    pci_target_dphase_ctrl_if.slave        bus
);
    typedef enum logic [2:0] {IDLE, TURNAR, DPHASE, STOPPING, FINISH} state_e;

    state_e      state_q, state_d;
    logic        trdyn_q, trdyn_d;
    logic        stopn_q, stopn_d;
    logic        ad_oe_q, ad_oe_d;
    logic        busy_q, busy_d;
    logic [1:0]  sel_q, sel_d;
    logic [21:0] add_q, add_d;
    logic        we_q, we_d;
    logic        stb_q, stb_d;
    logic [2:0]  end_q, end_d;
    logic [7:0]  beat_q, beat_d;
    logic [7:0]  lat_q, lat_d;
    logic        start_any;
    logic        complete;
    logic [7:0]  lat_lim;

    assign start_any = bus.START_CFG_I | bus.START_MEM_I | bus.START_HPMEM_I;
    assign complete  = (state_q == DPHASE) && !trdyn_q && !bus.IRDYn_I;
    assign lat_lim   = (beat_q == 8'd0) ? 8'(INIT_LAT - 1) : 8'(SUBS_LAT - 1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        add_d   = add_q;
        we_d    = we_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        ad_oe_d = ad_oe_q;
        stb_d   = 1'b0;
        end_d   = 3'b000;

        case (state_q)
            IDLE: begin
                if (start_any) begin
                    if (bus.START_CFG_I)      sel_d = 2'd1;
                    else if (bus.START_MEM_I) sel_d = 2'd2;
                    else                      sel_d = 2'd3;
                    we_d    = bus.WR_I;
                    add_d   = bus.ADD_I;
                    beat_d  = 8'd0;
                    lat_d   = 8'd0;
                    state_d = bus.WR_I ? DPHASE : TURNAR;
                end
            end
            TURNAR: begin
                // Latency is measured from the claim, so the turnaround clock counts.
                lat_d   = lat_q + 8'd1;
                state_d = DPHASE;
            end
            DPHASE: begin
                if (complete) begin
                    stb_d  = 1'b1;
                    add_d  = add_q + 22'd1;
                    beat_d = beat_q + 8'd1;
                    lat_d  = 8'd0;
                    if (bus.FRAMEn_I)
                        state_d = FINISH;
                    else if (beat_q + 8'd1 == 8'(MAX_BURST))
                        state_d = STOPPING;
                end else begin
                    lat_d = lat_q + 8'd1;
                    if (lat_q == lat_lim)
                        state_d = STOPPING;
                end
            end
            STOPPING: begin
                if (bus.FRAMEn_I)
                    state_d = FINISH;
            end
            FINISH: begin
                // Select is kept through FINISH so the final strobe is still qualified.
                sel_d   = 2'd0;
                state_d = IDLE;
                case (sel_q)
                    2'd1:    end_d = 3'b001;
                    2'd2:    end_d = 3'b010;
                    2'd3:    end_d = 3'b100;
                    default: end_d = 3'b000;
                endcase
            end
            default: state_d = IDLE;
        endcase

        busy_d  = (state_d != IDLE);
        trdyn_d = !((state_d == DPHASE) && bus.LOC_RDY_I);
        stopn_d = (state_d != STOPPING);
        if (state_d == TURNAR)
            ad_oe_d = 1'b1;
        else if (state_d == FINISH || state_d == IDLE)
            ad_oe_d = 1'b0;
    end

    always_ff @(posedge PHY_CLK33_I) begin
        if (PHY_RST_I) begin
            state_q <= IDLE;
            trdyn_q <= 1'b1;
            stopn_q <= 1'b1;
            ad_oe_q <= 1'b0;
            busy_q  <= 1'b0;
            sel_q   <= 2'd0;
            add_q   <= 22'd0;
            we_q    <= 1'b0;
            stb_q   <= 1'b0;
            end_q   <= 3'b000;
            beat_q  <= 8'd0;
            lat_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            trdyn_q <= trdyn_d;
            stopn_q <= stopn_d;
            ad_oe_q <= ad_oe_d;
            busy_q  <= busy_d;
            sel_q   <= sel_d;
            add_q   <= add_d;
            we_q    <= we_d;
            stb_q   <= stb_d;
            end_q   <= end_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
        end
    end

    assign bus.TRDYn_O     = trdyn_q;
    assign bus.STOPn_O     = stopn_q;
    assign bus.AD_OE_O     = ad_oe_q;
    assign bus.BUSY_O      = busy_q;
    assign bus.LOC_SEL_O   = sel_q;
    assign bus.LOC_ADD_O   = add_q;
    assign bus.LOC_WE_O    = we_q;
    assign bus.LOC_STB_O   = stb_q;
    assign bus.END_CFG_O   = end_q[0];
    assign bus.END_MEM_O   = end_q[1];
    assign bus.END_HPMEM_O = end_q[2];
endmodule

// File: tb/tb_pci_target_dphase_ctrl.sv
// Directed bench for the PCI target data-phase sequencer.
// Acts as PCI master and backend; expectations are hand-derived constants.
module tb_pci_target_dphase_ctrl;
    logic clk;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;

    logic [21:0] stbs[$];
    logic [21:0] prev_add;
    int          n_end_cfg, n_end_mem, n_end_hp;

    pci_target_dphase_ctrl_if bus ();

    pci_target_dphase_ctrl #(
        .MAX_BURST (16),
        .INIT_LAT  (16),
        .SUBS_LAT  (8)
    ) dut (
        .PHY_CLK33_I (clk),
        .PHY_RST_I   (rst),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #15 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Backend view: address of each completed phase, and END pulse counts.
    always @(negedge clk) begin
        if (bus.LOC_STB_O) stbs.push_back(prev_add);
        prev_add = bus.LOC_ADD_O;
        if (bus.END_CFG_O)   n_end_cfg++;
        if (bus.END_MEM_O)   n_end_mem++;
        if (bus.END_HPMEM_O) n_end_hp++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic claim(input logic cfg, input logic mem, input logic hp,
                         input logic wr, input logic [21:0] a);
        stbs.delete();
        bus.START_CFG_I   = cfg;
        bus.START_MEM_I   = mem;
        bus.START_HPMEM_I = hp;
        bus.WR_I          = wr;
        bus.ADD_I         = a;
        bus.FRAMEn_I      = 1'b0;
        tick();
        bus.START_CFG_I   = 1'b0;
        bus.START_MEM_I   = 1'b0;
        bus.START_HPMEM_I = 1'b0;
    endtask

    task automatic master(input int nbeats, output int done);
        logic comp;
        done         = 0;
        bus.FRAMEn_I = (nbeats <= 1);
        bus.IRDYn_I  = 1'b0;
        for (int c = 0; c < 200 && done < nbeats && bus.STOPn_O; c++) begin
            comp = !bus.TRDYn_O && !bus.IRDYn_I;
            tick();
            if (comp) begin
                done++;
                if (done == nbeats - 1) bus.FRAMEn_I = 1'b1;
            end
        end
    endtask

    task automatic wait_end(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.END_CFG_O || bus.END_MEM_O || bus.END_HPMEM_O) && n < 100);
        if (n >= 100) chk("end_timeout", n, 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_trdyn"}, bus.TRDYn_O, 1);
        chk({tag, "_stopn"}, bus.STOPn_O, 1);
        chk({tag, "_adoe"},  bus.AD_OE_O, 0);
        chk({tag, "_busy"},  bus.BUSY_O, 0);
        chk({tag, "_sel"},   bus.LOC_SEL_O, 0);
    endtask

    initial begin
        int n;
        int done;
        int e;
        logic [21:0] wrap_exp [3];
        wrap_exp[0] = 22'h3FFFFE;
        wrap_exp[1] = 22'h3FFFFF;
        wrap_exp[2] = 22'h000000;

        rst = 1'b1;
        bus.START_CFG_I = 0; bus.START_MEM_I = 0; bus.START_HPMEM_I = 0;
        bus.WR_I = 0; bus.ADD_I = '0; bus.FRAMEn_I = 1; bus.IRDYn_I = 1; bus.LOC_RDY_I = 1;
        n_end_cfg = 0; n_end_mem = 0; n_end_hp = 0;
        repeat (3) tick();
        chk_idle("rst");
        chk("rst_add", bus.LOC_ADD_O, 0);
        chk("rst_we",  bus.LOC_WE_O, 0);
        chk("rst_stb", bus.LOC_STB_O, 0);
        chk("rst_end", {bus.END_CFG_O, bus.END_MEM_O, bus.END_HPMEM_O}, 0);
        rst = 1'b0;
        tick();

        // MEM write, 4 beats from 0x100
        bus.IRDYn_I = 0;
        claim(0, 1, 0, 1, 22'h000100);
        chk("w4_sel",   bus.LOC_SEL_O, 2);
        chk("w4_we",    bus.LOC_WE_O, 1);
        chk("w4_add",   bus.LOC_ADD_O, 22'h100);
        chk("w4_trdyn", bus.TRDYn_O, 0);
        chk("w4_adoe",  bus.AD_OE_O, 0);
        master(4, done);
        chk("w4_done", done, 4);
        wait_end(n);
        chk("w4_endlat", n, 1);
        chk("w4_endmem", bus.END_MEM_O, 1);
        chk_idle("w4_end");
        tick();
        chk("w4_endpulse", bus.END_MEM_O, 0);
        chk("w4_nstb", stbs.size(), 4);
        for (int i = 0; i < 4 && i < stbs.size(); i++)
            chk("w4_stbadd", stbs[i], 22'h100 + i);

        // CFG single read, MEM claimed in the same cycle loses
        claim(1, 1, 0, 0, 22'h000005);
        chk("r1_turn_adoe",  bus.AD_OE_O, 1);
        chk("r1_turn_trdyn", bus.TRDYn_O, 1);
        chk("r1_turn_sel",   bus.LOC_SEL_O, 1);
        chk("r1_turn_we",    bus.LOC_WE_O, 0);
        master(1, done);
        chk("r1_done", done, 1);
        chk("r1_fin_adoe", bus.AD_OE_O, 0);
        e = n_end_mem;
        wait_end(n);
        chk("r1_endcfg", bus.END_CFG_O, 1);
        chk("r1_endmem", bus.END_MEM_O, 0);
        chk_idle("r1_end");
        tick();
        chk("r1_nstb", stbs.size(), 1);
        if (stbs.size() > 0) chk("r1_stbadd", stbs[0], 22'h5);
        chk("r1_nomem", n_end_mem, e);

        // HPMEM read, master wants 20 beats, disconnect after 16
        claim(0, 0, 1, 0, 22'h000040);
        master(20, done);
        chk("b16_done",  done, 16);
        chk("b16_stopn", bus.STOPn_O, 0);
        chk("b16_trdyn", bus.TRDYn_O, 1);
        chk("b16_adoe",  bus.AD_OE_O, 1);
        repeat (3) tick();
        chk("b16_hold_stopn", bus.STOPn_O, 0);
        chk("b16_hold_stb",   bus.LOC_STB_O, 0);
        bus.FRAMEn_I = 1;
        wait_end(n);
        chk("b16_endlat", n, 2);
        chk("b16_endhp",  bus.END_HPMEM_O, 1);
        chk_idle("b16_end");
        tick();
        chk("b16_nstb", stbs.size(), 16);
        if (stbs.size() == 16) chk("b16_lastadd", stbs[15], 22'h4F);

        // MEM read, backend never ready: retry at the 16th clock, a CFG claim mid-way is ignored
        bus.LOC_RDY_I = 0;
        bus.IRDYn_I   = 0;
        e = n_end_cfg;
        claim(0, 1, 0, 0, 22'h000010);
        n = 0;
        while (bus.STOPn_O && n < 40) begin
            if (n == 5) bus.START_CFG_I = 1;
            tick();
            bus.START_CFG_I = 0;
            n++;
        end
        chk("ret_clk",   n, 16);
        chk("ret_sel",   bus.LOC_SEL_O, 2);
        chk("ret_trdyn", bus.TRDYn_O, 1);
        chk("ret_adoe",  bus.AD_OE_O, 1);
        repeat (2) tick();
        chk("ret_hold_stopn", bus.STOPn_O, 0);
        bus.FRAMEn_I = 1;
        wait_end(n);
        chk("ret_endlat", n, 2);
        chk("ret_endmem", bus.END_MEM_O, 1);
        tick();
        chk("ret_nstb",  stbs.size(), 0);
        chk("ret_nocfg", n_end_cfg, e);
        bus.LOC_RDY_I = 1;

        // Write with IRDY# stall after beat 2, then backend stall after beat 3
        claim(0, 1, 0, 1, 22'h000200);
        bus.IRDYn_I = 0;
        tick();
        tick();
        chk("st_add2", bus.LOC_ADD_O, 22'h202);
        bus.IRDYn_I = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("st_irdy_add", bus.LOC_ADD_O, 22'h202);
            chk("st_irdy_stb", bus.LOC_STB_O, 0);
        end
        bus.IRDYn_I   = 0;
        bus.LOC_RDY_I = 0;
        tick();
        chk("st_b3_stb",   bus.LOC_STB_O, 1);
        chk("st_b3_add",   bus.LOC_ADD_O, 22'h203);
        chk("st_b3_trdyn", bus.TRDYn_O, 1);
        n = 0;
        while (bus.STOPn_O && n < 40) begin
            tick();
            n++;
        end
        chk("st_subslat", n, 8);
        chk("st_add_hold", bus.LOC_ADD_O, 22'h203);
        bus.FRAMEn_I  = 1;
        bus.LOC_RDY_I = 1;
        wait_end(n);
        chk("st_endmem", bus.END_MEM_O, 1);
        tick();
        chk("st_nstb", stbs.size(), 3);
        for (int i = 0; i < 3 && i < stbs.size(); i++)
            chk("st_stbadd", stbs[i], 22'h200 + i);

        // Address wrap across the top of the dword space
        claim(0, 1, 0, 1, 22'h3FFFFE);
        master(3, done);
        wait_end(n);
        chk("wr_endmem", bus.END_MEM_O, 1);
        tick();
        chk("wr_nstb", stbs.size(), 3);
        for (int i = 0; i < 3 && i < stbs.size(); i++)
            chk("wr_stbadd", stbs[i], wrap_exp[i]);

        // Reset in the middle of a burst
        e = n_end_cfg + n_end_mem + n_end_hp;
        claim(0, 0, 1, 1, 22'h3FFFFE);
        bus.IRDYn_I = 0;
        tick();
        tick();
        chk("mr_busy", bus.BUSY_O, 1);
        rst = 1;
        tick();
        chk_idle("mr");
        chk("mr_add", bus.LOC_ADD_O, 0);
        chk("mr_we",  bus.LOC_WE_O, 0);
        chk("mr_stb", bus.LOC_STB_O, 0);
        chk("mr_end", {bus.END_CFG_O, bus.END_MEM_O, bus.END_HPMEM_O}, 0);
        rst = 0;
        bus.FRAMEn_I = 1;
        bus.IRDYn_I  = 1;
        repeat (4) tick();
        chk("mr_noend", n_end_cfg + n_end_mem + n_end_hp, e);
        chk("mr_idle_busy", bus.BUSY_O, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
